rx_buffer_ctrl: RTL and testbench
=================================

Name: rx_buffer_ctrl

Overview:
Receive-side controller between the UART receiver (its rdy/ferr/data outputs) and the byte consumer (MAC/framing logic).
- Captures each received byte, with its framing-error flag, into a first-word-fall-through FIFO.
- Applies the framing-error drop policy and tracks overrun and error statistics.
- Detects end-of-burst from line idle time, so downstream logic can delimit frames without a length field.

Parameters:
- DEPTH, 16, FIFO depth in bytes; power of 2, minimum 2.
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line baud rate.
- IDLE_BYTES, 2, idle gap that ends a burst, in byte times (10 bit times each).
- DROP_FERR, 0, 1 = discard bytes received with ferr; 0 = store them with a flag.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- rx_rdy, in, 1, receiver byte-ready; level signal, one event per 0->1 edge.
- rx_ferr, in, 1, receiver framing error; sampled on the rx_rdy rising edge.
- rx_data, in, 8, receiver byte; sampled on the rx_rdy rising edge.
- rd_en, in, 1, consumer pops the head entry.
- clr_ovr, in, 1, clears the sticky overrun flag.
- dout, out, 8, head byte; valid when empty=0.
- dout_ferr, out, 1, framing-error flag of the head byte.
- empty, out, 1, FIFO empty.
- full, out, 1, FIFO full.
- count, out, $clog2(DEPTH)+1, current occupancy.
- overrun, out, 1, sticky: a byte was lost because the FIFO was full.
- err_count, out, 8, saturating count of framing errors.
- eof, out, 1, one-cycle pulse: line idle for IDLE_BYTES after the last byte.

Behaviour:
- Reset (synchronous, active-high, clk edge): all outputs below take their reset value and state returns to IDLE.
  - empty=1, full=0, count=0, overrun=0, err_count=0, eof=0.
  - dout=0, dout_ferr=0.
  - Internal pointers cleared.
  - rx_rdy edge register loaded with the current rx_rdy, so a level already high at reset release is not captured.
- Event detect: ev = rx_rdy & ~rx_rdy_q. Exactly one capture per event, whatever the rdy pulse length.
- On ev with rx_ferr=1:
  - err_count increments, saturating at 255.
  - If DROP_FERR=1, the byte is not written, but it still counts as line activity for eof.
- Write request: wr = ev & ~(rx_ferr & DROP_FERR).
- Write/read at the clock edge:
  - Effective read rd = rd_en & ~empty; rd_en while empty is ignored, with no state change.
  - wr & ~full: entry {rx_ferr, rx_data} written at the tail.
  - wr & full & ~rd: byte dropped, overrun set to 1.
  - wr & full & rd: read and write both occur; count stays at DEPTH, no overrun.
  - wr & empty: entry appears on dout the next cycle (1-cycle write-to-visible latency); empty falls the same cycle.
- Pointers:
  - $clog2(DEPTH) bits wide, wrap modulo DEPTH.
  - count = writes - reads; full = (count==DEPTH), empty = (count==0).
- overrun: sticky until clr_ovr=1 or reset. If clr_ovr and a new overrun occur in the same cycle, set wins.
- Idle/eof FSM (counter width sized to IDLE_CYCLES):
  - IDLE_CYCLES = IDLE_BYTES*10*CLK_FREQ/BAUD, integer division.
  - IDLE (disarmed): on ev -> ARMED, idle counter = 0.
  - ARMED: counter increments each clk; any ev restarts it at 0.
  - ARMED, counter == IDLE_CYCLES-1 with no ev that cycle: eof=1 for one cycle, -> IDLE.
  - ARMED, ev coincides with the terminal count: no eof, counter restarts.
  - eof fires at most once per burst; it never fires without a preceding byte event since reset.
- Reset mid-operation discards all buffered data, pending eof and statistics.

Test Plan:
1. Single byte: reset, then rx_rdy high 5 cycles with rx_data=8'hA5, rx_ferr=0 -> one write only; next cycle empty=0, count=1, dout=8'hA5, dout_ferr=0. rd_en 1 cycle -> empty=1, count=0.
2. Fill and overrun (DEPTH=16): 17 events with bytes 0x00..0x10, no reads -> full=1 after the 16th, overrun=1 after the 17th. Draining returns 0x00..0x0F in order. clr_ovr -> overrun=0.
3. Full with simultaneous read: FIFO full, event with 8'h55 in the same cycle as rd_en -> overrun stays 0, count stays 16, 8'h55 appears last on drain.
4. Framing errors: DROP_FERR=0, event with rx_ferr=1, data 8'h3C -> stored, dout_ferr=1, err_count=1. DROP_FERR=1, same event -> count unchanged, err_count=1. 300 error events -> err_count=255.
5. eof timing (CLK_FREQ=100e6, BAUD=9600, IDLE_BYTES=2, IDLE_CYCLES=208333):
   - One event -> eof pulses exactly 208333 cycles later, width 1, once only.
   - A second event 100000 cycles after the first -> eof 208333 cycles after the second.
6. Reset mid-operation: count=5 with ARMED -> reset -> empty=1, count=0, overrun=0, err_count=0, and no eof pulse afterwards.

Source files
------------

// File: rtl/rx_buffer_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : rx_buffer_ctrl_if
//  Description : Signal bundle between the UART receiver, the receive buffer
//                controller and the byte consumer.
//                Receiver side : rx_rdy, rx_ferr, rx_data
//                Consumer side : rd_en, clr_ovr -> dout, dout_ferr, empty,
//                                full, count, overrun, err_count, eof
//                slave  : view taken by rx_buffer_ctrl
//                master : view taken by the environment driving it
//  Revision    : 1.0 - initial release
// ============================================================================
interface rx_buffer_ctrl_if #(
    parameter int DEPTH = 16
);
    localparam int c_CW = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

    logic             rx_rdy;
    logic             rx_ferr;
    logic [7:0]       rx_data;
    logic             rd_en;
    logic             clr_ovr;
    logic [7:0]       dout;
    logic             dout_ferr;
    logic             empty;
    logic             full;
    logic [c_CW-1:0]  count;
    logic             overrun;
    logic [7:0]       err_count;
    logic             eof;

    modport master (
        output rx_rdy, rx_ferr, rx_data, rd_en, clr_ovr,
        input  dout, dout_ferr, empty, full, count, overrun, err_count, eof
    );

    modport slave (
        input  rx_rdy, rx_ferr, rx_data, rd_en, clr_ovr,
        output dout, dout_ferr, empty, full, count, overrun, err_count, eof
    );
endinterface
`default_nettype wire

// File: rtl/rx_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rx_buffer_ctrl
//  Description : Receive-side buffer controller. Captures every byte from the
//                UART receiver (one capture per rx_rdy rising edge) together
//                with its framing-error flag into a first-word-fall-through
//                FIFO, applies the framing-error drop policy, keeps sticky
//                overrun and saturating error statistics, and emits a
//                one-cycle eof pulse once the line has been idle for
//                IDLE_BYTES byte times after the last byte.
//  Ports       : clk   - system clock
//                reset - synchronous active-high reset
//                bus   - rx_buffer_ctrl_if.slave (receiver + consumer side)
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_buffer_ctrl #(
    parameter int DEPTH      = 16,
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int IDLE_BYTES = 2,
    parameter int DROP_FERR  = 0
) (
    input  wire logic       clk,
    input  wire logic       reset,
    rx_buffer_ctrl_if.slave bus
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int     c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int     c_CW = c_AW + 1;

    // Computed in 64 bits: IDLE_BYTES*10*CLK_FREQ overflows 32 bits easily.
    localparam longint c_IDLE_CYCLES =
        (longint'(IDLE_BYTES) * 64'sd10 * longint'(CLK_FREQ)) / longint'(BAUD);
    localparam int     c_IDLE_W = (c_IDLE_CYCLES > 2) ? $clog2(c_IDLE_CYCLES) : 1;

    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(c_IDLE_CYCLES - 1);
    localparam logic [c_CW-1:0]     c_FULL_CNT  = c_CW'(DEPTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ARMED = 1'b1;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic                r_rdy_q;
    logic                w_ev;
    logic                w_wr;
    logic                w_rd;
    logic                w_wr_ok;
    logic                w_ovr_set;
    logic                w_empty;
    logic                w_full;

    logic [8:0]          r_mem [DEPTH];
    logic [8:0]          w_head;
    logic [c_AW-1:0]     r_wr_ptr;
    logic [c_AW-1:0]     r_rd_ptr;
    logic [c_CW-1:0]     r_count;
    logic                r_overrun;
    logic [7:0]          r_err_count;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic [c_IDLE_W-1:0] w_idle_cnt_nxt;
    logic                w_eof_set;
    logic                r_eof;

    // ------------------------------------------------------------------------
    // Receiver event detect. The edge register is loaded even during reset so
    // that a rx_rdy level already high at reset release is not taken as a
    // new byte.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        r_rdy_q <= bus.rx_rdy;
    end

    assign w_ev = bus.rx_rdy & ~r_rdy_q;

    // Framing-error policy: dropped bytes still count as line activity (w_ev)
    // for the idle timer, they simply never reach the FIFO.
    generate
        if (DROP_FERR != 0) begin : g_drop_ferr
            assign w_wr = w_ev & ~bus.rx_ferr;
        end else begin : g_keep_ferr
            assign w_wr = w_ev;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------------
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL_CNT);
    assign w_rd      = bus.rd_en & ~w_empty;
    // When full, a simultaneous pop frees the head slot, which is exactly the
    // slot the write pointer addresses, so the write may proceed.
    assign w_wr_ok   = w_wr & (~w_full | w_rd);
    assign w_ovr_set = w_wr & w_full & ~w_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_wr_ok, w_rd})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= {bus.rx_ferr, bus.rx_data};
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    // ------------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun   <= 1'b0;
            r_err_count <= 8'h00;
        end else begin
            // A fresh overrun takes priority over a clear in the same cycle.
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_ovr) begin
                r_overrun <= 1'b0;
            end
            if (w_ev && bus.rx_ferr && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'h01;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Idle / end-of-burst FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idle_cnt <= '0;
            r_eof      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
            r_eof      <= w_eof_set;
        end
    end

    // Next-state logic: the counter runs only while ARMED and any byte event
    // restarts it, including one landing on the terminal count.
    always_comb begin
        w_state_nxt    = r_state;
        w_idle_cnt_nxt = r_idle_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_ev) begin
                    w_state_nxt    = S_ARMED;
                    w_idle_cnt_nxt = '0;
                end
            end
            S_ARMED: begin
                if (w_ev) begin
                    w_idle_cnt_nxt = '0;
                end else if (r_idle_cnt == c_IDLE_LAST) begin
                    w_state_nxt    = S_IDLE;
                    w_idle_cnt_nxt = '0;
                end else begin
                    w_idle_cnt_nxt = r_idle_cnt + c_IDLE_W'(1);
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_idle_cnt_nxt = '0;
            end
        endcase
    end

    // Output logic: request the eof pulse on the terminal idle count; it is
    // registered, so eof appears IDLE_CYCLES clocks after the last event.
    always_comb begin
        w_eof_set = 1'b0;
        if ((r_state == S_ARMED) && !w_ev && (r_idle_cnt == c_IDLE_LAST)) begin
            w_eof_set = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.dout      = w_empty ? 8'h00 : w_head[7:0];
    assign bus.dout_ferr = ~w_empty & w_head[8];
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.count     = r_count;
    assign bus.overrun   = r_overrun;
    assign bus.err_count = r_err_count;
    assign bus.eof       = r_eof;

endmodule
`default_nettype wire

// File: tb/tb_rx_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_buffer_ctrl
//  Description : Directed self-checking bench for rx_buffer_ctrl. Two
//                instances share one stimulus: dut_k keeps framing-error
//                bytes, dut_d drops them. CLK_FREQ=100_000 / BAUD=9600 with
//                IDLE_BYTES=2 gives an idle window of 2*10*100000/9600 = 208
//                cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_buffer_ctrl;

    localparam int c_IDLE = 208;

    logic       clk;
    logic       reset;
    logic       rx_rdy;
    logic       rx_ferr;
    logic [7:0] rx_data;
    logic       rd_en;
    logic       clr_ovr;

    int n_checks;
    int n_errors;
    int cyc;
    int first_k;
    int first_d;
    int hi_k;
    int hi_d;

    rx_buffer_ctrl_if #(.DEPTH(16)) ifk ();
    rx_buffer_ctrl_if #(.DEPTH(16)) ifd ();

    assign ifk.rx_rdy  = rx_rdy;
    assign ifk.rx_ferr = rx_ferr;
    assign ifk.rx_data = rx_data;
    assign ifk.rd_en   = rd_en;
    assign ifk.clr_ovr = clr_ovr;
    assign ifd.rx_rdy  = rx_rdy;
    assign ifd.rx_ferr = rx_ferr;
    assign ifd.rx_data = rx_data;
    assign ifd.rd_en   = rd_en;
    assign ifd.clr_ovr = clr_ovr;

    rx_buffer_ctrl #(
        .DEPTH(16), .CLK_FREQ(100_000), .BAUD(9600), .IDLE_BYTES(2), .DROP_FERR(0)
    ) dut_k (
        .clk(clk), .reset(reset), .bus(ifk)
    );

    rx_buffer_ctrl #(
        .DEPTH(16), .CLK_FREQ(100_000), .BAUD(9600), .IDLE_BYTES(2), .DROP_FERR(1)
    ) dut_d (
        .clk(clk), .reset(reset), .bus(ifd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One byte event: rdy high for 'hold' cycles, then low for one cycle.
    task automatic send(input logic [7:0] d, input logic f, input int hold);
        rx_data = d;
        rx_ferr = f;
        rx_rdy  = 1'b1;
        repeat (hold) tick();
        rx_rdy  = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_mon();
        first_k = -1;
        first_d = -1;
        hi_k    = 0;
        hi_d    = 0;
        cyc     = 0;
    endtask

    // Advance n cycles, recording eof activity relative to the last mark.
    task automatic run(input int n);
        repeat (n) begin
            tick();
            cyc++;
            if (ifk.eof === 1'b1) begin
                hi_k++;
                if (first_k < 0) first_k = cyc;
            end
            if (ifd.eof === 1'b1) begin
                hi_d++;
                if (first_d < 0) first_d = cyc;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        rx_rdy   = 1'b0;
        rx_ferr  = 1'b0;
        rx_data  = 8'h00;
        rd_en    = 1'b0;
        clr_ovr  = 1'b0;
        clear_mon();
        tick();
        tick();

        // ---- reset state ----
        check("rst_empty",     ifk.empty,     1);
        check("rst_full",      ifk.full,      0);
        check("rst_count",     ifk.count,     0);
        check("rst_overrun",   ifk.overrun,   0);
        check("rst_err_count", ifk.err_count, 0);
        check("rst_eof",       ifk.eof,       0);
        check("rst_dout",      ifk.dout,      0);
        check("rst_dout_ferr", ifk.dout_ferr, 0);

        // ---- rdy level already high at reset release is not a byte ----
        rx_rdy = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("rdy_at_release", ifk.count, 0);
        rx_rdy = 1'b0;
        tick();

        // ---- single byte, long rdy pulse ----
        rx_data = 8'hA5;
        rx_ferr = 1'b0;
        rx_rdy  = 1'b1;
        tick();
        check("t1_empty_latency", ifk.empty, 0);
        check("t1_dout",          ifk.dout,  8'hA5);
        repeat (4) tick();
        rx_rdy = 1'b0;
        tick();
        check("t1_count_once", ifk.count,     1);
        check("t1_dout_ferr",  ifk.dout_ferr, 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t1_pop_empty", ifk.empty, 1);
        check("t1_pop_count", ifk.count, 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t1_rd_while_empty", ifk.count, 0);

        // ---- fill and overrun ----
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1);
        check("t2_full",        ifk.full,    1);
        check("t2_count16",     ifk.count,   16);
        check("t2_no_overrun",  ifk.overrun, 0);
        send(8'h10, 1'b0, 1);
        check("t2_overrun",     ifk.overrun, 1);
        check("t2_count_kept",  ifk.count,   16);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t2_drain_%0d", i), ifk.dout, i);
            tick();
        end
        rd_en = 1'b0;
        check("t2_drained",        ifk.empty,   1);
        check("t2_overrun_sticky", ifk.overrun, 1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("t2_clr_ovr", ifk.overrun, 0);

        // ---- full with simultaneous read and write ----
        for (int i = 0; i < 16; i++) send(8'h80 + 8'(i), 1'b0, 1);
        rx_data = 8'h55;
        rx_rdy  = 1'b1;
        rd_en   = 1'b1;
        tick();
        rx_rdy  = 1'b0;
        rd_en   = 1'b0;
        check("t3_no_overrun", ifk.overrun, 0);
        check("t3_count16",    ifk.count,   16);
        tick();
        rd_en = 1'b1;
        for (int i = 1; i < 16; i++) begin
            check($sformatf("t3_drain_%0d", i), ifk.dout, 8'h80 + i);
            tick();
        end
        check("t3_last_55", ifk.dout, 8'h55);
        tick();
        rd_en = 1'b0;
        check("t3_drained", ifk.empty, 1);

        // ---- overrun and clear in the same cycle: set wins ----
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1);
        rx_data = 8'h77;
        rx_rdy  = 1'b1;
        clr_ovr = 1'b1;
        tick();
        rx_rdy  = 1'b0;
        clr_ovr = 1'b0;
        check("t3_set_wins", ifk.overrun, 1);
        tick();

        // ---- framing errors ----
        do_reset();
        check("t4_rst_count", ifk.count, 0);
        send(8'h3C, 1'b1, 1);
        check("t4k_count",     ifk.count,     1);
        check("t4k_dout",      ifk.dout,      8'h3C);
        check("t4k_dout_ferr", ifk.dout_ferr, 1);
        check("t4k_err",       ifk.err_count, 1);
        check("t4d_count",     ifd.count,     0);
        check("t4d_empty",     ifd.empty,     1);
        check("t4d_err",       ifd.err_count, 1);
        for (int i = 0; i < 300; i++) send(8'(i), 1'b1, 1);
        check("t4k_err_sat",  ifk.err_count, 255);
        check("t4d_err_sat",  ifd.err_count, 255);
        check("t4d_count_0",  ifd.count,     0);

        // ---- eof: single event (dropped ferr byte still arms dut_d) ----
        do_reset();
        tick();
        clear_mon();
        rx_ferr = 1'b1;
        rx_rdy  = 1'b1;
        run(1);
        cyc    = 0;
        rx_rdy = 1'b0;
        run(400);
        check("t5a_first_k", first_k, c_IDLE);
        check("t5a_hi_k",    hi_k,    1);
        check("t5a_first_d", first_d, c_IDLE);
        check("t5a_hi_d",    hi_d,    1);

        // ---- eof: second event 100 cycles after the first ----
        clear_mon();
        rx_ferr = 1'b0;
        rx_rdy  = 1'b1;
        run(1);
        rx_rdy  = 1'b0;
        run(99);
        rx_rdy  = 1'b1;
        run(1);
        cyc    = 0;
        rx_rdy = 1'b0;
        run(400);
        check("t5b_first_k", first_k, c_IDLE);
        check("t5b_hi_k",    hi_k,    1);

        // ---- eof: event coincides with terminal count ----
        clear_mon();
        rx_rdy = 1'b1;
        run(1);
        rx_rdy = 1'b0;
        run(c_IDLE - 1);
        rx_rdy = 1'b1;
        run(1);
        cyc    = 0;
        rx_rdy = 1'b0;
        run(400);
        check("t5c_first_k", first_k, c_IDLE);
        check("t5c_hi_k",    hi_k,    1);

        // ---- reset mid-operation ----
        do_reset();
        tick();
        send(8'h01, 1'b0, 1);
        send(8'h02, 1'b1, 1);
        send(8'h03, 1'b0, 1);
        send(8'h04, 1'b0, 1);
        send(8'h05, 1'b0, 1);
        check("t6_count5", ifk.count,     5);
        check("t6_err1",   ifk.err_count, 1);
        do_reset();
        check("t6_empty",   ifk.empty,     1);
        check("t6_count",   ifk.count,     0);
        check("t6_overrun", ifk.overrun,   0);
        check("t6_err",     ifk.err_count, 0);
        check("t6_eof",     ifk.eof,       0);
        clear_mon();
        run(400);
        check("t6_no_eof_k", hi_k, 0);
        check("t6_no_eof_d", hi_d, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
